// File: rtl/polyphase_interp_filt.sv
// Polyphase interpolation FIR: one sample in, INTERP_FACTOR filtered samples out.
// Optional build macro INTERP_FILT_SAT_EN: saturate on narrowing instead of wrap.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_data/valid/ready     input sample stream (signed)
//   out_data/valid/ready    output sample stream (signed)
//   out_phase               polyphase branch of the current out_data
//   tap_coeffs              prototype taps h[j] at bits [j*TAP_COEFF_WIDTH +: TAP_COEFF_WIDTH]
module polyphase_interp_filt #(
    parameter int DATA_WIDTH      = 16,
    parameter int TAP_COEFF_WIDTH = 16,
    parameter int TAPS_PER_PHASE  = 4,
    parameter int INTERP_FACTOR   = 4,
    parameter int OUT_SHIFT       = 15
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(INTERP_FACTOR)-1:0]     out_phase,
    input  logic [TAP_COEFF_WIDTH*TAPS_PER_PHASE*INTERP_FACTOR-1:0] tap_coeffs
);

    localparam int PW = $clog2(INTERP_FACTOR);
    localparam int AW = DATA_WIDTH + TAP_COEFF_WIDTH + $clog2(TAPS_PER_PHASE);
    localparam logic [PW-1:0] LAST = PW'(INTERP_FACTOR - 1);

    logic [DATA_WIDTH-1:0]  r_x [TAPS_PER_PHASE];
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_valid;
    logic [PW-1:0]          r_phase;

    logic [DATA_WIDTH-1:0]  w_x [TAPS_PER_PHASE];
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic [PW-1:0]          w_ph;
    logic signed [AW-1:0]   w_acc;
    logic signed [AW:0]     w_rnd;
    logic signed [AW:0]     w_shf;
    logic [DATA_WIDTH-1:0]  w_res;

    assign in_ready  = !r_valid || (out_ready && r_phase == LAST);
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = r_valid && out_ready;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_phase = r_phase;

    // Line the next result is computed from: shifted on input, else as held.
    always_comb begin
        w_x[0] = w_in_hs ? in_data : r_x[0];
        for (int k = 1; k < TAPS_PER_PHASE; k++) begin
            w_x[k] = w_in_hs ? r_x[k-1] : r_x[k];
        end
    end

    assign w_ph = w_in_hs ? '0 : r_phase + 1'b1;

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < TAPS_PER_PHASE; k++) begin
            w_acc = w_acc
                + AW'($signed(tap_coeffs[(k * INTERP_FACTOR + int'(w_ph))
                                         * TAP_COEFF_WIDTH +: TAP_COEFF_WIDTH]))
                * AW'($signed(w_x[k]));
        end
    end

    // One guard bit keeps the rounding add from overflowing the accumulator.
    generate
        if (OUT_SHIFT > 0) begin : g_rnd
            localparam logic signed [AW:0] RND = (AW+1)'(1) <<< (OUT_SHIFT - 1);
            assign w_rnd = (AW+1)'(w_acc) + RND;
        end else begin : g_nornd
            assign w_rnd = (AW+1)'(w_acc);
        end
    endgenerate

    assign w_shf = w_rnd >>> OUT_SHIFT;

`ifdef INTERP_FILT_SAT_EN
    localparam logic signed [AW:0] MAXV =
        (AW+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW:0] MINV = -MAXV - (AW+1)'(1);

    always_comb begin
        if (w_shf > MAXV)      w_res = DATA_WIDTH'(MAXV);
        else if (w_shf < MINV) w_res = DATA_WIDTH'(MINV);
        else                   w_res = DATA_WIDTH'(w_shf);
    end
`else
    assign w_res = DATA_WIDTH'(w_shf);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_phase <= '0;
            r_data  <= '0;
            for (int k = 0; k < TAPS_PER_PHASE; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS_PER_PHASE; k++) begin
                r_x[k] <= w_x[k];
            end
            if (w_in_hs) begin
                r_valid <= 1'b1;
                r_phase <= '0;
                r_data  <= w_res;
            end else if (w_out_hs) begin
                // Phase stays at LAST when draining; only a new sample wraps it.
                if (r_phase == LAST) begin
                    r_valid <= 1'b0;
                end else begin
                    r_phase <= w_ph;
                    r_data  <= w_res;
                end
            end
        end
    end

endmodule
